// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// bus mode encoding and the byte-lane write merge helper.
package clint_pkg;

  localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
  localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
  localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
  localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Lanes with a set strobe take the new byte, the others keep the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = wstrb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime counter with per-word byte-granular write ports
// and the registered mtime >= mtimecmp comparison.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lo_we,
  input  logic        hi_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [63:0] mtimecmp_next,
  output logic [63:0] mtime,
  output logic        timer_intr
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] presc_next_s;
  logic               tick_s;
  logic [63:0]        mtime_r;
  logic [63:0]        mtime_next_s;
  logic               timer_intr_r;

  // Prescaler state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_next_s;
    end
  end

  // Prescaler next state: count up to the last value, then wrap.
  always_comb begin
    presc_next_s = presc_r;
    if (presc_r == PRESC_LAST) begin
      presc_next_s = '0;
    end else begin
      presc_next_s = presc_r + PRESC_W'(1);
    end
  end

  // Prescaler output: one tick per TICK_DIV cycles.
  always_comb begin
    tick_s = (presc_r == PRESC_LAST);
  end

  // A word write replaces the increment for that cycle; no carry crosses words.
  always_comb begin
    mtime_next_s = mtime_r;
    if (lo_we) begin
      mtime_next_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], wdata, wstrb)};
    end else if (hi_we) begin
      mtime_next_s = {merge_bytes(mtime_r[63:32], wdata, wstrb), mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
  end

  // mtime and the compare flag, both from next-state values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_r      <= 64'd0;
      timer_intr_r <= 1'b0;
    end else begin
      mtime_r      <= mtime_next_s;
      timer_intr_r <= (mtime_next_s >= mtimecmp_next);
    end
  end

  assign mtime      = mtime_r;
  assign timer_intr = timer_intr_r;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped msip, mtimecmp and mtime with a
// fixed one-cycle response, driving the core's interrupt and time inputs.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        response_enable,
  output logic [31:0] resp_data,
  output logic        software_intr,
  output logic        timer_intr,
  output logic [63:0] time_full
);

  localparam logic [31:0] ADDR_MASK = (ADDR_BITS >= 32) ? 32'hFFFF_FFFC :
                                      (((32'd1 << ADDR_BITS) - 32'd1) & 32'hFFFF_FFFC);

  logic [31:0] off_s;
  logic        wr_s;
  logic        sel_msip_s;
  logic        sel_cmp_lo_s;
  logic        sel_cmp_hi_s;
  logic        sel_time_lo_s;
  logic        sel_time_hi_s;
  logic [31:0] rdata_s;
  logic [63:0] mtimecmp_r;
  logic [63:0] mtimecmp_next_s;
  logic        msip_r;
  logic        msip_next_s;
  logic        resp_en_r;
  logic [31:0] resp_data_r;
  logic [63:0] mtime_s;
  logic        timer_intr_s;

  // Address decode on the word offset only.
  always_comb begin
    off_s         = req_addr & ADDR_MASK;
    wr_s          = request_enable && (req_mode == MODE_WRITE);
    sel_msip_s    = (off_s == MSIP_OFF);
    sel_cmp_lo_s  = (off_s == MTIMECMP_LO_OFF);
    sel_cmp_hi_s  = (off_s == MTIMECMP_HI_OFF);
    sel_time_lo_s = (off_s == MTIME_LO_OFF);
    sel_time_hi_s = (off_s == MTIME_HI_OFF);
  end

  // Read mux over current register contents; unmapped offsets read zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (off_s)
      MSIP_OFF:        rdata_s = {31'd0, msip_r};
      MTIMECMP_LO_OFF: rdata_s = mtimecmp_r[31:0];
      MTIMECMP_HI_OFF: rdata_s = mtimecmp_r[63:32];
      MTIME_LO_OFF:    rdata_s = mtime_s[31:0];
      MTIME_HI_OFF:    rdata_s = mtime_s[63:32];
      default:         rdata_s = 32'h0000_0000;
    endcase
  end

  // Next-state mtimecmp and msip from byte-strobed writes.
  always_comb begin
    mtimecmp_next_s = mtimecmp_r;
    msip_next_s     = msip_r;
    if (wr_s && sel_cmp_lo_s) begin
      mtimecmp_next_s[31:0] = merge_bytes(mtimecmp_r[31:0], req_wdata, req_wstrb);
    end else if (wr_s && sel_cmp_hi_s) begin
      mtimecmp_next_s[63:32] = merge_bytes(mtimecmp_r[63:32], req_wdata, req_wstrb);
    end else begin
      mtimecmp_next_s = mtimecmp_r;
    end
    if (wr_s && sel_msip_s && req_wstrb[0]) begin
      msip_next_s = req_wdata[0];
    end else begin
      msip_next_s = msip_r;
    end
  end

  // Software-visible registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r     <= 1'b0;
    end else begin
      mtimecmp_r <= mtimecmp_next_s;
      msip_r     <= msip_next_s;
    end
  end

  // Response pipeline: data is captured only on a request and held otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_en_r   <= 1'b0;
      resp_data_r <= 32'h0000_0000;
    end else begin
      resp_en_r <= request_enable;
      if (request_enable) begin
        resp_data_r <= (req_mode == MODE_WRITE) ? 32'h0000_0000 : rdata_s;
      end else begin
        resp_data_r <= resp_data_r;
      end
    end
  end

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk           (clk),
    .rstn          (rstn),
    .lo_we         (wr_s && sel_time_lo_s),
    .hi_we         (wr_s && sel_time_hi_s),
    .wdata         (req_wdata),
    .wstrb         (req_wstrb),
    .mtimecmp_next (mtimecmp_next_s),
    .mtime         (mtime_s),
    .timer_intr    (timer_intr_s)
  );

  assign response_enable = resp_en_r;
  assign resp_data       = resp_data_r;
  assign software_intr   = msip_r;
  assign timer_intr      = timer_intr_s;
  assign time_full       = mtime_s;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: a TICK_DIV=1 instance (a_*) and a TICK_DIV=4
// instance (b_*) sharing clock and reset.
module tb_clint;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        a_req_en = 1'b0, b_req_en = 1'b0;
  logic        a_mode = 1'b0, b_mode = 1'b0;
  logic [31:0] a_addr = 32'd0, b_addr = 32'd0;
  logic [31:0] a_wdata = 32'd0, b_wdata = 32'd0;
  logic [3:0]  a_wstrb = 4'd0, b_wstrb = 4'd0;
  logic        a_resp_en, b_resp_en;
  logic [31:0] a_resp_data, b_resp_data;
  logic        a_sw, b_sw, a_ti, b_ti;
  logic [63:0] a_time, b_time;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clint #(.TICK_DIV(1), .ADDR_BITS(16)) u_a (
    .clk(clk), .rstn(rstn), .request_enable(a_req_en), .req_mode(a_mode),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
    .response_enable(a_resp_en), .resp_data(a_resp_data),
    .software_intr(a_sw), .timer_intr(a_ti), .time_full(a_time)
  );

  clint #(.TICK_DIV(4), .ADDR_BITS(16)) u_b (
    .clk(clk), .rstn(rstn), .request_enable(b_req_en), .req_mode(b_mode),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
    .response_enable(b_resp_en), .resp_data(b_resp_data),
    .software_intr(b_sw), .timer_intr(b_ti), .time_full(b_time)
  );

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_data;
    logic        exp_sw;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the response captured.
  task automatic req(input bit on_b, input logic mode, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic resp_en, output logic [31:0] data);
    if (on_b) begin
      b_req_en = 1'b1; b_mode = mode; b_addr = addr; b_wdata = wdata; b_wstrb = wstrb;
    end else begin
      a_req_en = 1'b1; a_mode = mode; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
    end
    @(negedge clk);
    resp_en = on_b ? b_resp_en : a_resp_en;
    data    = on_b ? b_resp_data : a_resp_data;
    a_req_en = 1'b0;
    b_req_en = 1'b0;
  endtask

  // Returns at the negedge where rstn is released; no clock edges since then.
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
    end
  endtask

  initial begin
    logic        re;
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 32'h0000_4000, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_4004, 32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 4'hF, 32'h0,         1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0001, 1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0,         4'h2, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0001, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_1234, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[7]  = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h0000_4000, 32'h1234_5678, 4'h5, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, 32'hFF34_FF78, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_4000, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, 32'hFF34_FF78, 1'b1};
    vecs[12] = '{1'b1, 32'h0000_4004, 32'hAABB_CCDD, 4'h8, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'h0000_4004, 32'h0,         4'h0, 32'hAAFF_FFFF, 1'b1};
    vecs[14] = '{1'b0, 32'h0001_4000, 32'h0,         4'h0, 32'hFF34_FF78, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_0000, 32'h0,         4'h1, 32'h0,         1'b0};
    vecs[16] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[17] = '{1'b0, 32'h0000_4002, 32'h0,         4'h0, 32'hFF34_FF78, 1'b0};

    // Reset values while rstn is held low.
    @(negedge clk);
    check("rst_resp_en", {63'd0, a_resp_en}, 64'd0);
    check("rst_resp_data", {32'd0, a_resp_data}, 64'd0);
    check("rst_sw", {63'd0, a_sw}, 64'd0);
    check("rst_ti", {63'd0, a_ti}, 64'd0);
    check("rst_time", a_time, 64'd0);

    // Idle count on both prescaler settings, then back-to-back reads.
    do_reset();
    idle(10);
    check("idle_time10", a_time, 64'd10);
    check("idle_ti", {63'd0, a_ti}, 64'd0);
    check("idle_sw", {63'd0, a_sw}, 64'd0);
    check("idle_resp_en", {63'd0, a_resp_en}, 64'd0);
    idle(2);
    check("div4_time12", b_time, 64'd3);
    begin
      logic [31:0] exp_b2b [6];
      exp_b2b = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd4, 32'd4};
      for (int i = 0; i < 6; i++) begin
        req(1'b1, 1'b0, 32'h0000_BFF8, 32'h0, 4'h0, re, rd);
        check($sformatf("b2b_en%0d", i), {63'd0, re}, 64'd1);
        check($sformatf("b2b_data%0d", i), {32'd0, rd}, {32'd0, exp_b2b[i]});
      end
    end
    idle(1);
    check("b2b_resp_drop", {63'd0, b_resp_en}, 64'd0);
    check("b2b_resp_hold", {32'd0, b_resp_data}, 64'd4);
    req(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, re, rd);
    check("cmp_lo_rst_en", {63'd0, re}, 64'd1);
    check("cmp_lo_rst", {32'd0, rd}, 64'hFFFF_FFFF);

    // Register access table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req(1'b0, vecs[i].mode, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, re, rd);
      check($sformatf("vec%0d_en", i), {63'd0, re}, 64'd1);
      check($sformatf("vec%0d_data", i), {32'd0, rd}, {32'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_sw", i), {63'd0, a_sw}, {63'd0, vecs[i].exp_sw});
      check($sformatf("vec%0d_ti", i), {63'd0, a_ti}, 64'd0);
    end

    // Timer interrupt rises at mtime 20 and drops after mtimecmp is raised.
    do_reset();
    req(1'b0, 1'b1, 32'h0000_4004, 32'h0, 4'hF, re, rd);
    req(1'b0, 1'b1, 32'h0000_4000, 32'd20, 4'hF, re, rd);
    check("ti_after_cmp", {63'd0, a_ti}, 64'd0);
    for (int k = 3; k <= 24; k++) begin
      idle(1);
      check($sformatf("ti_cycle%0d", k), {63'd0, a_ti}, {63'd0, (k >= 20)});
    end
    check("ti_time24", a_time, 64'd24);
    req(1'b0, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, re, rd);
    check("ti_drop_lo", {63'd0, a_ti}, 64'd0);
    req(1'b0, 1'b1, 32'h0000_4004, 32'hFFFF_FFFF, 4'hF, re, rd);
    check("ti_drop_hi", {63'd0, a_ti}, 64'd0);
    check("ti_time26", a_time, 64'd26);

    // mtime word writes coincide with ticks; write wins, then wrap.
    do_reset();
    req(1'b0, 1'b1, 32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, re, rd);
    check("wr_lo_no_carry", a_time, 64'h0000_0000_FFFF_FFFF);
    req(1'b0, 1'b1, 32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, re, rd);
    check("wr_hi_wins", a_time, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_max_ti", {63'd0, a_ti}, 64'd1);
    idle(1);
    check("wrap_zero", a_time, 64'd0);
    check("wrap_ti", {63'd0, a_ti}, 64'd0);
    idle(1);
    check("wrap_one", a_time, 64'd1);

    // Reset arriving right after a request drops its response.
    do_reset();
    req(1'b0, 1'b1, 32'h0000_0000, 32'h1, 4'h1, re, rd);
    check("pre_sw", {63'd0, a_sw}, 64'd1);
    req(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, re, rd);
    check("pre_data", {32'd0, rd}, 64'hFFFF_FFFF);
    a_req_en = 1'b1; a_mode = 1'b0; a_addr = 32'h0000_4004;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    a_req_en = 1'b0;
    @(negedge clk);
    check("mid_rst_resp_en", {63'd0, a_resp_en}, 64'd0);
    check("mid_rst_resp_data", {32'd0, a_resp_data}, 64'd0);
    check("mid_rst_sw", {63'd0, a_sw}, 64'd0);
    check("mid_rst_ti", {63'd0, a_ti}, 64'd0);
    check("mid_rst_time", a_time, 64'd0);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check($sformatf("post_rst_no_resp%0d", k), {63'd0, a_resp_en}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
